// File: rtl/bus_controller.sv
// bus_controller: round-robin snooping-bus arbiter and 8x4 main memory for a 3-CPU MSI system.
// Replies are steered only to the requester's bus_in so foreign replies are never observed.
module bus_controller #(
    parameter int SNOOP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [12:0] bus_out_0,
    input  logic [12:0] bus_out_1,
    input  logic [12:0] bus_out_2,
    output logic [12:0] bus_in_0,
    output logic [12:0] bus_in_1,
    output logic [12:0] bus_in_2,
    output logic        busy,
    input  logic        dbg_we,
    input  logic [2:0]  dbg_addr,
    input  logic [3:0]  dbg_wdata,
    output logic [3:0]  dbg_rdata
);
    typedef enum logic [1:0] {IDLE, BCAST, SNOOP, REPLY} state_t;

    state_t      r_state, w_next;
    logic [12:0] w_bus_out [3];
    logic [12:0] w_bus_in  [3];
    logic [12:0] r_bus_in  [3];
    logic [2:0]  r_pending;
    logic [2:0]  r_pcmd    [3];
    logic [2:0]  r_paddr   [3];
    logic [1:0]  r_rr_ptr, r_req_id, w_grant, w_p1, w_p2;
    logic [2:0]  r_addr, r_cnt;
    logic        r_wb_hit, r_busy, w_take;
    logic [3:0]  r_wb_data, w_take_data, w_rdata;
    logic [3:0]  r_mem     [8];

    assign w_bus_out[0] = bus_out_0;
    assign w_bus_out[1] = bus_out_1;
    assign w_bus_out[2] = bus_out_2;
    assign bus_in_0     = r_bus_in[0];
    assign bus_in_1     = r_bus_in[1];
    assign bus_in_2     = r_bus_in[2];
    assign busy         = r_busy;
    assign dbg_rdata    = r_mem[dbg_addr];

    assign w_p1    = (r_rr_ptr == 2'd2) ? 2'd0 : r_rr_ptr + 2'd1;
    assign w_p2    = (r_rr_ptr == 2'd0) ? 2'd2 : r_rr_ptr - 2'd1;
    assign w_grant = r_pending[r_rr_ptr] ? r_rr_ptr : r_pending[w_p1] ? w_p1 : w_p2;

    // Descending scan so the lowest-numbered matching responder wins.
    always_comb begin
        w_take      = 1'b0;
        w_take_data = '0;
        for (int j = 2; j >= 0; j--) begin
            if (r_state == SNOOP && !r_wb_hit && 2'(j) != r_req_id &&
                (w_bus_out[j][12] || w_bus_out[j][11]) && w_bus_out[j][6:4] == r_addr) begin
                w_take      = 1'b1;
                w_take_data = w_bus_out[j][3:0];
            end
        end
    end

    // Reply data reflects memory as it will read during REPLY, including same-edge writes.
    assign w_rdata = w_take ? w_take_data :
                     r_wb_hit ? r_wb_data :
                     (dbg_we && dbg_addr == r_addr) ? dbg_wdata : r_mem[r_addr];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = |r_pending ? BCAST : IDLE;
            BCAST:   w_next = SNOOP;
            SNOOP:   w_next = (r_cnt == 3'd1) ? REPLY : SNOOP;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            w_bus_in[j] = '0;
            if (r_state == IDLE && |r_pending && 2'(j) != w_grant)
                w_bus_in[j] = {3'b000, r_pcmd[w_grant], r_paddr[w_grant], 4'b0000};
            if (r_state == SNOOP && r_cnt == 3'd1 && 2'(j) == r_req_id)
                w_bus_in[j] = {3'b001, 3'b000, r_addr, w_rdata};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_pending <= '0;
            r_req_id  <= '0;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_wb_hit  <= 1'b0;
            r_wb_data <= '0;
            r_busy    <= 1'b0;
            for (int i = 0; i < 8; i++) r_mem[i] <= '0;
            for (int i = 0; i < 3; i++) begin
                r_bus_in[i] <= '0;
                r_pcmd[i]   <= '0;
                r_paddr[i]  <= '0;
            end
        end else begin
            r_busy <= (w_next != IDLE);
            for (int i = 0; i < 3; i++) r_bus_in[i] <= w_bus_in[i];
            if (r_state == IDLE && |r_pending) begin
                r_req_id <= w_grant;
                r_addr   <= r_paddr[w_grant];
                r_wb_hit <= 1'b0;
            end
            if (r_state == BCAST) r_cnt <= 3'(SNOOP_CYCLES);
            if (r_state == SNOOP) r_cnt <= r_cnt - 3'd1;
            if (w_take) begin
                r_wb_hit  <= 1'b1;
                r_wb_data <= w_take_data;
            end
            if (r_state == REPLY) begin
                r_pending[r_req_id] <= 1'b0;
                r_rr_ptr            <= (r_req_id == 2'd2) ? 2'd0 : r_req_id + 2'd1;
            end
            // A new pulse placed after the REPLY clear so a same-edge set dominates.
            for (int i = 0; i < 3; i++) begin
                if (w_bus_out[i][10]) begin
                    r_pending[i] <= 1'b1;
                    r_pcmd[i]    <= w_bus_out[i][9:7];
                    r_paddr[i]   <= w_bus_out[i][6:4];
                end
            end
            if (dbg_we) r_mem[dbg_addr] <= dbg_wdata;
            if (w_take) r_mem[r_addr] <= w_take_data;
        end
    end
endmodule

// File: tb/tb_bus_controller.sv
// tb_bus_controller: directed vector table plus hand-written multi-cycle sequences for bus_controller.
module tb_bus_controller;
    localparam int S = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] bus_out_0 = '0, bus_out_1 = '0, bus_out_2 = '0;
    logic [12:0] bus_in_0, bus_in_1, bus_in_2;
    logic        busy;
    logic        dbg_we = 1'b0;
    logic [2:0]  dbg_addr = 3'd5;
    logic [3:0]  dbg_wdata = '0;
    logic [3:0]  dbg_rdata;
    logic [12:0] w_bi [3];

    int n_checks = 0;
    int n_fail   = 0;

    bus_controller #(.SNOOP_CYCLES(S)) dut (
        .clock(clock), .reset(reset),
        .bus_out_0(bus_out_0), .bus_out_1(bus_out_1), .bus_out_2(bus_out_2),
        .bus_in_0(bus_in_0), .bus_in_1(bus_in_1), .bus_in_2(bus_in_2),
        .busy(busy), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
    );

    always #5 clock = ~clock;

    assign w_bi[0] = bus_in_0;
    assign w_bi[1] = bus_in_1;
    assign w_bi[2] = bus_in_2;

    typedef struct {
        logic        rst;
        logic [12:0] o0, o1, o2;
        logic        we;
        logic [3:0]  wd;
        logic [12:0] e0, e1, e2;
        logic        eb;
        logic [3:0]  er;
    } vec_t;

    vec_t tv [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    // Records each reply bit seen over 20 cycles and checks requester order and timing.
    task automatic watch(input int n_exp, input int first, input logic [5:0] ids);
        int rc = 0;
        for (int c = 1; c <= 20; c++) begin
            tick;
            for (int k = 0; k < 3; k++) begin
                if (w_bi[k][10]) begin
                    if (rc < n_exp) begin
                        chk("reply_id", k, 32'(ids[2*rc +: 2]));
                        chk("reply_cycle", c, first + (3 + S) * rc);
                    end
                    rc++;
                end
            end
        end
        chk("reply_count", rc, n_exp);
    endtask

    initial begin
        //        rst o0       o1       o2       we wd     e0       e1       e2       eb er
        tv[0]  = '{1, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   0, 4'h0};
        tv[1]  = '{0, 13'h0,   13'h0,   13'h0,   1, 4'h9, 13'h0,   13'h0,   13'h0,   0, 4'h9};
        tv[2]  = '{0, 13'h0,   13'h650, 13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   0, 4'h9};
        tv[3]  = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h250, 13'h0,   13'h250, 1, 4'h9};
        tv[4]  = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   1, 4'h9};
        tv[5]  = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   1, 4'h9};
        tv[6]  = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h459, 13'h0,   1, 4'h9};
        tv[7]  = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   0, 4'h9};
        tv[8]  = '{0, 13'h0,   13'h0,   13'h4B0, 0, 4'h0, 13'h0,   13'h0,   13'h0,   0, 4'h9};
        tv[9]  = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0B0, 13'h0B0, 13'h0,   1, 4'h9};
        tv[10] = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   1, 4'h9};
        tv[11] = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   1, 4'h9};
        tv[12] = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h430, 1, 4'h9};
        tv[13] = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   0, 4'h9};
        tv[14] = '{0, 13'h650, 13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   0, 4'h9};
        tv[15] = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h250, 13'h250, 1, 4'h9};
        tv[16] = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   1, 4'h9};
        tv[17] = '{0, 13'h0,   13'h1047,13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   1, 4'h9};
        tv[18] = '{0, 13'h0,   13'h0,   13'h853, 0, 4'h0, 13'h453, 13'h0,   13'h0,   1, 4'h3};
        tv[19] = '{0, 13'h0,   13'h0,   13'h0,   0, 4'h0, 13'h0,   13'h0,   13'h0,   0, 4'h3};

        tick;
        for (int i = 0; i < 20; i++) begin
            reset = tv[i].rst; bus_out_0 = tv[i].o0; bus_out_1 = tv[i].o1; bus_out_2 = tv[i].o2;
            dbg_we = tv[i].we; dbg_addr = 3'd5; dbg_wdata = tv[i].wd;
            tick;
            chk($sformatf("vec%0d_bus_in_0", i), bus_in_0, tv[i].e0);
            chk($sformatf("vec%0d_bus_in_1", i), bus_in_1, tv[i].e1);
            chk($sformatf("vec%0d_bus_in_2", i), bus_in_2, tv[i].e2);
            chk($sformatf("vec%0d_busy", i), busy, tv[i].eb);
            chk($sformatf("vec%0d_dbg_rdata", i), dbg_rdata, tv[i].er);
        end
        reset = 0; bus_out_0 = '0; bus_out_1 = '0; bus_out_2 = '0; dbg_we = 0;

        // Write-back forwarding, same-edge dbg collision, first response wins.
        dbg_we = 1; dbg_addr = 3'd2; dbg_wdata = 4'h3; tick; dbg_we = 0;
        chk("wb_preload", dbg_rdata, 4'h3);
        bus_out_0 = 13'h0620; tick; bus_out_0 = '0;
        tick;
        chk("wb_bcast_in2", bus_in_2, 13'h0220);
        tick;
        bus_out_2 = 13'h102A; dbg_we = 1; dbg_wdata = 4'h5; tick; bus_out_2 = '0; dbg_we = 0;
        chk("wb_collision_mem", dbg_rdata, 4'hA);
        bus_out_1 = 13'h102B; tick; bus_out_1 = '0;
        chk("wb_reply_in0", bus_in_0, 13'h042A);
        chk("wb_reply_in1", bus_in_1, 13'h0);
        chk("wb_reply_in2", bus_in_2, 13'h0);
        tick;
        chk("wb_mem_after", dbg_rdata, 4'hA);
        chk("wb_idle_busy", busy, 1'b0);

        // Arbitration from reset: simultaneous pulses served 0,1,2.
        reset = 1; tick; reset = 0;
        bus_out_0 = 13'h0610; bus_out_1 = 13'h0620; bus_out_2 = 13'h0630; tick;
        bus_out_0 = '0; bus_out_1 = '0; bus_out_2 = '0;
        watch(3, 2 + S, {2'd2, 2'd1, 2'd0});
        // rr pointer back at 0: CPU0 wins over CPU1.
        bus_out_0 = 13'h0610; bus_out_1 = 13'h0620; tick;
        bus_out_0 = '0; bus_out_1 = '0;
        watch(2, 2 + S, {2'd0, 2'd1, 2'd0});

        // Queued request during BCAST of CPU0's transaction.
        bus_out_0 = 13'h0610; tick; bus_out_0 = '0;
        tick;
        chk("queue_bcast_in1", bus_in_1, 13'h0210);
        bus_out_1 = 13'h0620; tick; bus_out_1 = '0;
        watch(2, S, {2'd0, 2'd1, 2'd0});

        // Reset during SNOOP with another request pending.
        dbg_we = 1; dbg_addr = 3'd3; dbg_wdata = 4'h7; tick; dbg_we = 0;
        bus_out_2 = 13'h0630; tick; bus_out_2 = '0;
        bus_out_0 = 13'h0610; tick; bus_out_0 = '0;
        tick;
        chk("rst_pre_busy", busy, 1'b1);
        reset = 1; tick; reset = 0;
        chk("rst_in0", bus_in_0, 13'h0);
        chk("rst_in1", bus_in_1, 13'h0);
        chk("rst_in2", bus_in_2, 13'h0);
        chk("rst_busy", busy, 1'b0);
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a); #1;
            chk($sformatf("rst_mem%0d", a), dbg_rdata, 4'h0);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("rst_no_pending", busy, 1'b0);
        end
        bus_out_1 = 13'h0630; tick; bus_out_1 = '0;
        for (int c = 0; c < 2 + S; c++) tick;
        chk("post_rst_reply_in1", bus_in_1, 13'h0430);
        chk("post_rst_reply_in0", bus_in_0, 13'h0);
        tick;
        chk("post_rst_idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
